// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared types and constants for the memory access unit.
// State and operation encodings, default widths, and the width of the
// latency/timeout down-counter.
package mem_access_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;
    localparam int CNT_W      = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

endpackage

// File: rtl/mem_access_unit_lat_counter.sv
// lat_counter: loadable down-counter with a "count equals 1" flag.
// A load takes priority over a decrement; the count never goes below 0.
module lat_counter
    import mem_access_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         one_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load, else decrement while non-zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign one_o = (cnt_q == W'(1));

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: performs one read or write to the shared data memory on
// behalf of a core. Latches address/data, arbitrates with mem_req/mem_gnt,
// waits RD_LATENCY cycles for read data, then pulses done (and inc_out).
// Optional macro MEM_TIMEOUT_EN: abandon the grant wait after
// TIMEOUT_CYCLES REQ cycles and pulse err instead of done.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int RD_LATENCY     = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic              auto_inc,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rd_data,
    output logic              inc_out,
    output logic              err,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            state_q, state_d;
    op_t               op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              inc_q, inc_d;
    logic              lat_load, lat_dec, lat_one;

    lat_counter #(.W(CNT_W)) u_lat (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (lat_load),
        .load_val_i (CNT_W'(RD_LATENCY)),
        .dec_i      (lat_dec),
        .one_o      (lat_one)
    );

`ifdef MEM_TIMEOUT_EN
    logic to_q, to_d;
    logic to_load, to_dec, to_one;

    // Grant-wait counter: loaded on acceptance, counts down each ungranted REQ cycle
    lat_counter #(.W(CNT_W)) u_to (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (to_load),
        .load_val_i (CNT_W'(TIMEOUT_CYCLES)),
        .dec_i      (to_dec),
        .one_o      (to_one)
    );
`endif

    // Next-state and latch update logic
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        inc_d    = inc_q;
        lat_load = 1'b0;
        lat_dec  = 1'b0;
`ifdef MEM_TIMEOUT_EN
        to_d     = to_q;
        to_load  = 1'b0;
        to_dec   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (rd_req || wr_req) begin
                    addr_d  = addr_in;
                    wdata_d = wr_data;
                    inc_d   = auto_inc;
                    // A simultaneous read is dropped in favour of the write
                    op_d    = wr_req ? OP_WR : OP_RD;
                    state_d = REQ;
`ifdef MEM_TIMEOUT_EN
                    to_d    = 1'b0;
                    to_load = 1'b1;
`endif
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    if (op_q == OP_WR) begin
                        state_d = DONE;
                    end else begin
                        lat_load = 1'b1;
                        state_d  = WAIT;
                    end
                end
`ifdef MEM_TIMEOUT_EN
                else begin
                    to_dec = 1'b1;
                    if (to_one) begin
                        // Timed out: DONE cycle reports err instead of done
                        to_d    = 1'b1;
                        state_d = DONE;
                    end
                end
`endif
            end
            WAIT: begin
                lat_dec = 1'b1;
                if (lat_one) begin
                    rdata_d = mem_rdata;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
`ifdef MEM_TIMEOUT_EN
                to_d    = 1'b0;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latch registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= OP_RD;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            inc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            inc_q   <= inc_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    // Timeout flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_q <= 1'b0;
        end else begin
            to_q <= to_d;
        end
    end

    assign done = (state_q == DONE) && !to_q;
    assign err  = (state_q == DONE) && to_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign done = (state_q == DONE);
    assign err  = 1'b0;
`endif

    assign busy      = (state_q != IDLE);
    assign inc_out   = done && inc_q;
    assign mem_req   = (state_q == REQ);
    assign mem_we    = mem_req && (op_q == OP_WR);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rd_data   = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench for mem_access_unit.
// Expected completion results are queued when a request is issued and
// popped when done is observed.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] addr_in = '0;
    logic [15:0] wr_data = '0;
    logic        rd_req = 1'b0;
    logic        wr_req = 1'b0;
    logic        auto_inc = 1'b0;
    logic        busy, done, inc_out, err, mem_req, mem_we;
    logic [15:0] rd_data, mem_addr, mem_wdata;
    logic        mem_gnt = 1'b0;
    logic [15:0] mem_rdata = '0;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] rdata;
        logic        inc;
    } exp_t;
    exp_t        sb_q[$];
    logic [15:0] exp_rd = '0;

    int   busy_cnt = 0;
    int   done_cnt = 0;
    int   inc_cnt  = 0;
    int   req_eps  = 0;
    logic req_prev = 1'b0;

    mem_access_unit #(
        .ADDR_W(16), .DATA_W(16), .RD_LATENCY(2), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .addr_in(addr_in), .wr_data(wr_data),
        .rd_req(rd_req), .wr_req(wr_req), .auto_inc(auto_inc),
        .busy(busy), .done(done), .rd_data(rd_data), .inc_out(inc_out),
        .err(err), .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (busy)    busy_cnt <= busy_cnt + 1;
        if (done)    done_cnt <= done_cnt + 1;
        if (inc_out) inc_cnt  <= inc_cnt + 1;
        if (mem_req && !req_prev) req_eps <= req_eps + 1;
        req_prev <= mem_req;
    end

    task automatic wait_done(input int max_cyc, output int cyc, output bit seen);
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if ({busy, done, inc_out, err} !== 4'b0)
            begin failures++; $display("FAIL reset_status got=%b want=0000", {busy, done, inc_out, err}); end
        checks++; if ({mem_req, mem_we} !== 2'b0)
            begin failures++; $display("FAIL reset_mem_ctl got=%b want=00", {mem_req, mem_we}); end
        checks++; if (mem_addr !== 16'h0 || mem_wdata !== 16'h0)
            begin failures++; $display("FAIL reset_latches got=%h/%h want=0000/0000", mem_addr, mem_wdata); end
        checks++; if (rd_data !== 16'h0)
            begin failures++; $display("FAIL reset_rd_data got=%h want=0000", rd_data); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write();
        int cyc; bit seen; exp_t e;
        @(posedge clk); #1;
        addr_in = 16'h1234; wr_data = 16'hBEEF; wr_req = 1'b1; auto_inc = 1'b0;
        e.rdata = exp_rd; e.inc = 1'b0; sb_q.push_back(e);
        @(posedge clk); #1;
        wr_req = 1'b0; addr_in = 16'hFFFF; wr_data = 16'h0000; mem_gnt = 1'b1;
        @(negedge clk);
        checks++; if ({mem_req, mem_we, busy} !== 3'b111)
            begin failures++; $display("FAIL wr_req_phase got=%b want=111", {mem_req, mem_we, busy}); end
        checks++; if (mem_addr !== 16'h1234)
            begin failures++; $display("FAIL wr_mem_addr got=%h want=1234", mem_addr); end
        checks++; if (mem_wdata !== 16'hBEEF)
            begin failures++; $display("FAIL wr_mem_wdata got=%h want=beef", mem_wdata); end
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        wait_done(10, cyc, seen);
        checks++; if (!seen || cyc != 1)
            begin failures++; $display("FAIL wr_done_latency got=%0d seen=%0d want=1", cyc, seen); end
        if (seen) begin
            e = sb_q.pop_front();
            checks++; if (rd_data !== e.rdata)
                begin failures++; $display("FAIL wr_rd_data got=%h want=%h", rd_data, e.rdata); end
            checks++; if (inc_out !== e.inc || busy !== 1'b1)
                begin failures++; $display("FAIL wr_done_flags got=%b%b want=%b1", inc_out, busy, e.inc); end
        end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0)
            begin failures++; $display("FAIL wr_idle got=%b%b want=00", busy, done); end
    endtask

    task automatic test_read_delayed_grant();
        int cyc; bit seen; exp_t e; int b0; int r0;
        b0 = busy_cnt; r0 = req_eps;
        mem_rdata = 16'hDEAD;
        @(posedge clk); #1;
        addr_in = 16'h0042; rd_req = 1'b1;
        exp_rd = 16'hA5A5; e.rdata = exp_rd; e.inc = 1'b0; sb_q.push_back(e);
        @(posedge clk); #1;
        rd_req = 1'b0;
        @(negedge clk);
        checks++; if ({mem_req, mem_we} !== 2'b10 || mem_addr !== 16'h0042)
            begin failures++; $display("FAIL rd_req_phase got=%b %h want=10 0042", {mem_req, mem_we}, mem_addr); end
        repeat (3) @(posedge clk);
        #1 mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        @(posedge clk); #1;
        mem_rdata = 16'hA5A5;
        wait_done(10, cyc, seen);
        mem_rdata = 16'h1111;
        checks++; if (!seen || cyc != 2)
            begin failures++; $display("FAIL rd_done_latency got=%0d seen=%0d want=2", cyc, seen); end
        if (seen) begin
            e = sb_q.pop_front();
            checks++; if (rd_data !== e.rdata)
                begin failures++; $display("FAIL rd_data got=%h want=%h", rd_data, e.rdata); end
        end
        repeat (2) @(negedge clk);
        checks++; if (rd_data !== 16'hA5A5)
            begin failures++; $display("FAIL rd_data_hold got=%h want=a5a5", rd_data); end
        checks++; if (busy_cnt - b0 != 7)
            begin failures++; $display("FAIL rd_busy_cycles got=%0d want=7", busy_cnt - b0); end
        checks++; if (req_eps - r0 != 1)
            begin failures++; $display("FAIL rd_req_episodes got=%0d want=1", req_eps - r0); end
    endtask

    task automatic test_rd_wr_collision();
        int cyc; bit seen; exp_t e; int d0; int i0; int r0;
        d0 = done_cnt; i0 = inc_cnt; r0 = req_eps;
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        addr_in = 16'h0100; wr_data = 16'h5555; rd_req = 1'b1; wr_req = 1'b1; auto_inc = 1'b1;
        e.rdata = exp_rd; e.inc = 1'b1; sb_q.push_back(e);
        @(posedge clk); #1;
        rd_req = 1'b0; wr_req = 1'b0; auto_inc = 1'b0;
        @(negedge clk);
        checks++; if ({mem_req, mem_we} !== 2'b11 || mem_wdata !== 16'h5555)
            begin failures++; $display("FAIL both_is_write got=%b %h want=11 5555", {mem_req, mem_we}, mem_wdata); end
        wait_done(10, cyc, seen);
        mem_gnt = 1'b0;
        checks++; if (!seen || cyc != 1)
            begin failures++; $display("FAIL both_done_latency got=%0d seen=%0d want=1", cyc, seen); end
        if (seen) begin
            e = sb_q.pop_front();
            checks++; if (inc_out !== e.inc || rd_data !== e.rdata)
                begin failures++; $display("FAIL both_done got=%b %h want=%b %h", inc_out, rd_data, e.inc, e.rdata); end
        end
        repeat (3) @(negedge clk);
        checks++; if (done_cnt - d0 != 1 || inc_cnt - i0 != 1)
            begin failures++; $display("FAIL both_pulse_count got=%0d/%0d want=1/1", done_cnt - d0, inc_cnt - i0); end
        checks++; if (req_eps - r0 != 1 || busy !== 1'b0)
            begin failures++; $display("FAIL both_single_access got=%0d busy=%b want=1 0", req_eps - r0, busy); end
    endtask

    task automatic test_busy_ignore();
        int cyc; bit seen; exp_t e; int d0; int r0;
        d0 = done_cnt; r0 = req_eps;
        mem_rdata = 16'h0F0F;
        @(posedge clk); #1;
        addr_in = 16'h0200; rd_req = 1'b1;
        exp_rd = 16'h0F0F; e.rdata = exp_rd; e.inc = 1'b0; sb_q.push_back(e);
        @(posedge clk); #1;
        rd_req = 1'b0; mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0; wr_req = 1'b1; addr_in = 16'h0BAD;
        @(posedge clk); #1;
        wr_req = 1'b0;
        wait_done(10, cyc, seen);
        checks++; if (!seen)
            begin failures++; $display("FAIL busy_done_timeout got=0 want=1"); end
        if (seen) begin
            e = sb_q.pop_front();
            checks++; if (rd_data !== e.rdata || mem_addr !== 16'h0200)
                begin failures++; $display("FAIL busy_rd got=%h %h want=%h 0200", rd_data, mem_addr, e.rdata); end
        end
        repeat (4) @(negedge clk);
        checks++; if (done_cnt - d0 != 1 || req_eps - r0 != 1 || busy !== 1'b0)
            begin failures++; $display("FAIL busy_ignored got=%0d/%0d/%b want=1/1/0", done_cnt - d0, req_eps - r0, busy); end
    endtask

    task automatic test_back_to_back();
        int cyc1; int cyc2; bit seen1; bit seen2; exp_t e;
        @(posedge clk); #1;
        addr_in = 16'h0300; wr_data = 16'h7777; wr_req = 1'b1; mem_gnt = 1'b1;
        e.rdata = exp_rd; e.inc = 1'b0; sb_q.push_back(e); sb_q.push_back(e);
        wait_done(10, cyc1, seen1);
        if (seen1) e = sb_q.pop_front();
        wait_done(10, cyc2, seen2);
        wr_req = 1'b0;
        checks++; if (!seen1 || !seen2 || cyc2 != 3)
            begin failures++; $display("FAIL b2b_done_gap got=%0d seen=%0d%0d want=3", cyc2, seen1, seen2); end
        if (seen2) begin
            e = sb_q.pop_front();
            checks++; if (rd_data !== e.rdata)
                begin failures++; $display("FAIL b2b_rd_data got=%h want=%h", rd_data, e.rdata); end
        end
        @(negedge clk);
        mem_gnt = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0)
            begin failures++; $display("FAIL b2b_idle got=%b want=0", busy); end
    endtask

    task automatic test_reset_mid();
        int cyc; bit seen; exp_t e; int d0;
        d0 = done_cnt;
        mem_rdata = 16'h9999;
        @(posedge clk); #1;
        addr_in = 16'h0777; rd_req = 1'b1;
        @(posedge clk); #1;
        rd_req = 1'b0; mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({mem_req, busy, done} !== 3'b000)
            begin failures++; $display("FAIL rst_async got=%b want=000", {mem_req, busy, done}); end
        @(negedge clk);
        rst_n = 1'b1;
        exp_rd = 16'h0000;
        sb_q.delete();
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0 || done_cnt != d0 || rd_data !== exp_rd)
            begin failures++; $display("FAIL rst_idle got=%b %0d %h want=0 0 %h", busy, done_cnt - d0, rd_data, exp_rd); end
        mem_rdata = 16'h3C3C;
        @(posedge clk); #1;
        addr_in = 16'h0555; rd_req = 1'b1;
        exp_rd = 16'h3C3C; e.rdata = exp_rd; e.inc = 1'b0; sb_q.push_back(e);
        @(posedge clk); #1;
        rd_req = 1'b0; mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        wait_done(10, cyc, seen);
        checks++; if (!seen || cyc != 3)
            begin failures++; $display("FAIL rst_next_latency got=%0d seen=%0d want=3", cyc, seen); end
        if (seen) begin
            e = sb_q.pop_front();
            checks++; if (rd_data !== e.rdata)
                begin failures++; $display("FAIL rst_next_rd got=%h want=%h", rd_data, e.rdata); end
        end
        @(negedge clk);
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        int n; bit seen; int d0;
        d0 = done_cnt; n = 0; seen = 1'b0;
        mem_gnt = 1'b0;
        @(posedge clk); #1;
        addr_in = 16'h0400; wr_req = 1'b1;
        @(posedge clk); #1;
        wr_req = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (err === 1'b1) seen = 1'b1;
            else if (mem_req === 1'b1) n++;
        end
        checks++; if (!seen || n != 4)
            begin failures++; $display("FAIL to_err got=%0d seen=%0d want=4", n, seen); end
        checks++; if (done !== 1'b0 || mem_req !== 1'b0 || inc_out !== 1'b0)
            begin failures++; $display("FAIL to_flags got=%b%b%b want=000", done, mem_req, inc_out); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || err !== 1'b0 || done_cnt != d0 || rd_data !== exp_rd)
            begin failures++; $display("FAIL to_idle got=%b%b %0d %h want=00 0 %h", busy, err, done_cnt - d0, rd_data, exp_rd); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_read_delayed_grant();
        test_rd_wr_collision();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
